mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage.
- Registers the execute-to-memory bus and the HI/LO write bundle, then post-processes synchronous data-SRAM read data:
  - byte/halfword select;
  - sign or zero extension.
- Selects the register-file writeback value and forwards it to decode (bypass) and to the writeback stage.
- Holds captured load data across pipeline stalls so a returned SRAM word is never lost.

Parameters:
- STALL_W, 6, width of stall vector; bit 3 = memory-stage input register, bit 4 = writeback-stage input register.
- EX_TO_MEM_WD, 80, width of execute-to-memory bus.
- MEM_TO_WB_WD, 70, width of memory-to-writeback bus.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- stall  in  STALL_W  pipeline stall vector, 1 = Stop.
- ex_to_mem_bus  in  80  {pc[79:48], data_ram_en[47], data_ram_wen[46:43], sel_rf_res[42], rf_we[41], rf_waddr[40:36], ex_result[35:4], data_ram_read[3:0]}.
- ex_to_mem1  in  66  {hi_we[65], lo_we[64], hi_i[63:32], lo_i[31:0]}.
- data_sram_rdata  in  32  SRAM read word; valid the cycle after the request, i.e. while the load occupies this stage.
- mem_to_wb_bus  out  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- mem_to_id_bus  out  38  {rf_we, rf_waddr, rf_wdata} bypass to decode.
- mem_to_wb1  out  66  registered HI/LO bundle to writeback.
- mem_to_id_2  out  66  same HI/LO bundle, bypass to decode.

Behaviour:
- Input register (bus_r, hilo_r) update rules, checked every posedge, first match wins:
  - rst: clear both to 0.
  - stall[3]=Stop and stall[4]=NoStop: load 0 (bubble).
  - stall[3]=NoStop: capture ex_to_mem_bus and ex_to_mem1.
  - otherwise: hold.
- All outputs are combinational from registered state, so every output reads 0 in the cycle after reset.
- data_ram_read codes:
  - 1111 = lw; 0001 = lb; 0010 = lbu; 0011 = lh; 0100 = lhu.
  - 0101 = sb; 0111 = sh; 0000 = no load.
  - A load is any code in {1111, 0001, 0010, 0011, 0100} with data_ram_en=1.
- Read-data hold register (rdata_hold, hold_valid):
  - Load in stage, stall[4]=Stop, hold_valid=0: rdata_hold <= data_sram_rdata; hold_valid <= 1.
  - hold_valid clears when the stage advances (stall[4]=NoStop), on a bubble, or on rst.
  - Effective word w = hold_valid ? rdata_hold : data_sram_rdata.
- Byte/halfword select, using a = ex_result[1:0]:
  - lb/lbu: byte at w[8a+7:8a]; lb sign-extends from bit 7, lbu zero-extends.
  - lh/lhu: a=00 selects w[15:0], a=10 selects w[31:16]; lh sign-extends, lhu zero-extends.
  - Misaligned halfword (a[0]=1) returns 0; no exception is raised.
  - lw: w unchanged.
- rf_wdata = sel_rf_res ? load_result : ex_result.
- Stores (0101, 0111, or data_ram_wen≠0 with sel_rf_res=0) pass ex_result; rf_we is taken from the bus as-is.
- mem_to_id_bus mirrors the rf_we, rf_waddr and rf_wdata fields of mem_to_wb_bus in the same cycle.
- mem_to_id_2 and mem_to_wb1 both equal hilo_r.
- Bubble/reset state: rf_we=0, hi_we=0, lo_we=0; no spurious writes or bypasses.
- Reset mid-stall clears bus_r and hold_valid in the same edge.
- Latency: one register stage; the load result is available combinationally in the SRAM-data cycle.

Test Plan:
- lb, addr 0x...02, rdata=0x12_80_34_56, sel_rf_res=1, waddr=5 → rf_wdata=0xFFFFFF80; mem_to_id_bus={1,5,0xFFFFFF80}.
- lhu, addr a=10, rdata=0x8001_0000 → rf_wdata=0x00008001; lh with same data → 0xFFFF8001.
- lw with stall[4]=Stop for 3 cycles, rdata changing to 0xDEADBEEF after cycle 1 (first word 0x11223344) → rf_wdata stays 0x11223344 throughout; hold_valid clears on advance.
- stall[3]=Stop, stall[4]=NoStop → next cycle mem_to_wb_bus rf_we=0 and mem_to_wb1=0 (bubble).
- ALU op, ex_result=0x0000ABCD, sel_rf_res=0, hi_we=1, hi_i=0x5 → rf_wdata=0xABCD; mem_to_wb1[65]=1, [63:32]=5.
- Assert rst during a held load → all outputs 0 next cycle and hold_valid=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// Execute-to-memory input bundles and memory-stage output bundles.
// slave: the stage (consumes EX/SRAM data, drives WB/bypass); master: its neighbours.
interface mem_stage_if #(
    parameter int EX_TO_MEM_WD = 80,
    parameter int MEM_TO_WB_WD = 70
);
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [65:0]             ex_to_mem1;
    logic [31:0]             data_sram_rdata;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [37:0]             mem_to_id_bus;
    logic [65:0]             mem_to_wb1;
    logic [65:0]             mem_to_id_2;

    modport master (
        output ex_to_mem_bus, ex_to_mem1, data_sram_rdata,
        input  mem_to_wb_bus, mem_to_id_bus, mem_to_wb1, mem_to_id_2
    );

    modport slave (
        input  ex_to_mem_bus, ex_to_mem1, data_sram_rdata,
        output mem_to_wb_bus, mem_to_id_bus, mem_to_wb1, mem_to_id_2
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: one register stage, load data formatted combinationally in the SRAM-data cycle.
// stall[3] holds (or bubbles) the input register; while stall[4] stops, the first returned load word is kept.
module mem_stage #(
    parameter int STALL_W      = 6,
    parameter int EX_TO_MEM_WD = 80,
    parameter int MEM_TO_WB_WD = 70
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    mem_stage_if.slave         bus
);
    localparam logic STOP = 1'b1;

    logic [EX_TO_MEM_WD-1:0] bus_q, bus_d;
    logic [65:0]             hilo_q, hilo_d;
    logic [31:0]             rdata_hold_q, rdata_hold_d;
    logic                    hold_valid_q, hold_valid_d;

    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [3:0]  data_ram_read;
    logic        is_load;

    assign pc            = bus_q[79:48];
    assign data_ram_en   = bus_q[47];
    assign data_ram_wen  = bus_q[46:43];
    assign sel_rf_res    = bus_q[42];
    assign rf_we         = bus_q[41];
    assign rf_waddr      = bus_q[40:36];
    assign ex_result     = bus_q[35:4];
    assign data_ram_read = bus_q[3:0];

    assign is_load = data_ram_en &&
                     (data_ram_read inside {4'b1111, 4'b0001, 4'b0010, 4'b0011, 4'b0100});

    always_comb begin
        bus_d        = bus_q;
        hilo_d       = hilo_q;
        rdata_hold_d = rdata_hold_q;
        hold_valid_d = hold_valid_q;
        if (stall[3] == STOP && stall[4] != STOP) begin
            bus_d  = '0;
            hilo_d = '0;
        end else if (stall[3] != STOP) begin
            bus_d  = bus.ex_to_mem_bus;
            hilo_d = bus.ex_to_mem1;
        end
        // Only the first word seen while stalled is valid; later SRAM reads may belong to other requests.
        if (stall[4] != STOP) begin
            hold_valid_d = 1'b0;
        end else if (is_load && !hold_valid_q) begin
            rdata_hold_d = bus.data_sram_rdata;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q        <= '0;
            hilo_q       <= '0;
            rdata_hold_q <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            bus_q        <= bus_d;
            hilo_q       <= hilo_d;
            rdata_hold_q <= rdata_hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    logic [31:0] word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_result;
    logic [31:0] rf_wdata;

    assign word     = hold_valid_q ? rdata_hold_q : bus.data_sram_rdata;
    assign byte_sel = word[{ex_result[1:0], 3'b000} +: 8];
    assign half_sel = ex_result[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_result = '0;
        case (data_ram_read)
            4'b1111: load_result = word;
            4'b0001: load_result = {{24{byte_sel[7]}}, byte_sel};
            4'b0010: load_result = {24'b0, byte_sel};
            4'b0011: load_result = ex_result[0] ? 32'b0 : {{16{half_sel[15]}}, half_sel};
            4'b0100: load_result = ex_result[0] ? 32'b0 : {16'b0, half_sel};
            default: load_result = '0;
        endcase
    end

    assign rf_wdata = sel_rf_res ? load_result : ex_result;

    assign bus.mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
    assign bus.mem_to_id_bus = {rf_we, rf_waddr, rf_wdata};
    assign bus.mem_to_wb1    = hilo_q;
    assign bus.mem_to_id_2   = hilo_q;

    // Store byte enables and the stall bits owned by other stages have no effect here.
    logic unused_ok;
    assign unused_ok = ^{data_ram_wen, stall[2:0], stall[STALL_W-1:5]};
endmodule
